// File: rtl/rs_unit_pkg.sv
// Shared types for the reservation station: ROB tag width, opcode width, and CDB/entry layouts.
// Holds the default-width payload structs used across the core.
package rs_unit_pkg;

  localparam int unsigned ROB_WIDTH  = 6;
  localparam int unsigned OP_WIDTH   = 6;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned RS_NSRC    = 2;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [XLEN-1:0]      data;
  } cdb_t;

  typedef struct packed {
    logic                         valid;
    logic [OP_WIDTH-1:0]          op;
    logic [ROB_WIDTH-1:0]         tag;
    logic [RS_NSRC-1:0]           src_rdy;
    logic [RS_NSRC*ROB_WIDTH-1:0] src_tag;
    logic [RS_NSRC*XLEN-1:0]      src_data;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Allocation-order tracker: age_q[i][j] set means entry i was allocated before entry j.
// Returns the one-hot oldest entry among those flagged ready.
module rs_age_matrix #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_d[i][j] = age_q[i][j];
        if (free[i] || free[j]) age_d[i][j] = 1'b0;
        // A new entry is younger than everything currently held.
        if (alloc[j] && (i != j)) age_d[i][j] = 1'b1;
        if (alloc[i]) age_d[i][j] = 1'b0;
        if (flush) age_d[i][j] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && age_q[j][i]) oldest[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: rtl/rs_unit.sv
// Reservation station for one functional unit: holds DEPTH instructions, snoops the CDB for
// missing operands and dispatches the oldest fully-ready entry, holding a stalled pick stable.
module rs_unit
  import rs_unit_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned N_CDB  = 1,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = ROB_WIDTH,
  parameter int unsigned OP_W   = OP_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [NSRC-1:0]            in_src_rdy,
  input  logic [NSRC*TAG_W-1:0]      in_src_tag,
  input  logic [NSRC*DATA_W-1:0]     in_src_data,
  input  logic [N_CDB-1:0]           cdb_valid,
  input  logic [N_CDB*TAG_W-1:0]     cdb_tag,
  input  logic [N_CDB*DATA_W-1:0]    cdb_data,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output logic [OP_W-1:0]            ex_op,
  output logic [TAG_W-1:0]           ex_tag,
  output logic [NSRC*DATA_W-1:0]     ex_src,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [OP_W-1:0]        op_q    [DEPTH];
  logic [OP_W-1:0]        op_d    [DEPTH];
  logic [TAG_W-1:0]       tag_q   [DEPTH];
  logic [TAG_W-1:0]       tag_d   [DEPTH];
  logic [NSRC-1:0]        rdy_q   [DEPTH];
  logic [NSRC-1:0]        rdy_d   [DEPTH];
  logic [NSRC*TAG_W-1:0]  stag_q  [DEPTH];
  logic [NSRC*TAG_W-1:0]  stag_d  [DEPTH];
  logic [NSRC*DATA_W-1:0] sdata_q [DEPTH];
  logic [NSRC*DATA_W-1:0] sdata_d [DEPTH];

  logic [CntW-1:0]  count_q, count_d;
  logic             lock_q, lock_d;
  logic [DEPTH-1:0] lock_oh_q, lock_oh_d;

  logic [DEPTH-1:0]  entry_rdy, oldest, sel, alloc_oh;
  logic              in_fire, ex_fire, found;
  logic              hit, multi, multi_hit;
  logic [DATA_W-1:0] hdata;

  // Lowest channel index wins when several broadcasts carry the same tag.
  function automatic void cdb_lookup(input  logic [TAG_W-1:0]  t,
                                     output logic              f_hit,
                                     output logic              f_multi,
                                     output logic [DATA_W-1:0] f_data);
    f_hit   = 1'b0;
    f_multi = 1'b0;
    f_data  = '0;
    for (int c = N_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == t)) begin
        f_multi = f_multi | f_hit;
        f_hit   = 1'b1;
        f_data  = cdb_data[c*DATA_W +: DATA_W];
      end
    end
  endfunction

  assign in_ready = (count_q != CntW'(DEPTH));
  assign count    = count_q;
  assign in_fire  = in_valid && in_ready && !flush;
  assign sel      = lock_q ? lock_oh_q : oldest;
  assign ex_valid = !flush && (|sel);
  assign ex_fire  = ex_valid && ex_ready;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_rdy[i] = valid_q[i] && (&rdy_q[i]);
  end

  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  rs_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .alloc  (in_fire ? alloc_oh : '0),
    .free   (ex_fire ? sel : '0),
    .ready  (entry_rdy),
    .oldest (oldest)
  );

  always_comb begin
    ex_op  = '0;
    ex_tag = '0;
    ex_src = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        ex_op  = ex_op | op_q[i];
        ex_tag = ex_tag | tag_q[i];
        ex_src = ex_src | sdata_q[i];
      end
    end
  end

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    tag_d     = tag_q;
    rdy_d     = rdy_q;
    stag_d    = stag_q;
    sdata_d   = sdata_q;
    multi_hit = 1'b0;
    hit       = 1'b0;
    multi     = 1'b0;
    hdata     = '0;

    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < NSRC; s++) begin
        if (valid_q[i] && !rdy_q[i][s]) begin
          cdb_lookup(stag_q[i][s*TAG_W +: TAG_W], hit, multi, hdata);
          multi_hit = multi_hit | multi;
          if (hit) begin
            rdy_d[i][s]                    = 1'b1;
            sdata_d[i][s*DATA_W +: DATA_W] = hdata;
          end
        end
      end
    end

    if (ex_fire) valid_d = valid_q & ~sel;

    if (in_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          valid_d[i] = 1'b1;
          op_d[i]    = in_op;
          tag_d[i]   = in_tag;
          stag_d[i]  = in_src_tag;
          rdy_d[i]   = in_src_rdy;
          sdata_d[i] = in_src_data;
          for (int s = 0; s < NSRC; s++) begin
            if (!in_src_rdy[s]) begin
              cdb_lookup(in_src_tag[s*TAG_W +: TAG_W], hit, multi, hdata);
              multi_hit = multi_hit | multi;
              if (hit) begin
                rdy_d[i][s]                    = 1'b1;
                sdata_d[i][s*DATA_W +: DATA_W] = hdata;
              end
            end
          end
        end
      end
    end

    if (flush) valid_d = '0;
  end

  always_comb begin
    lock_d    = lock_q;
    lock_oh_d = lock_oh_q;
    if (flush || ex_fire) begin
      lock_d    = 1'b0;
      lock_oh_d = '0;
    end else if (ex_valid) begin
      lock_d    = 1'b1;
      lock_oh_d = sel;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_fire && !ex_fire) begin
      count_d = count_q + CntW'(1);
    end else if (ex_fire && !in_fire) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      count_q   <= '0;
      lock_q    <= 1'b0;
      lock_oh_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= '0;
        tag_q[i]   <= '0;
        rdy_q[i]   <= '0;
        stag_q[i]  <= '0;
        sdata_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      lock_q    <= lock_d;
      lock_oh_q <= lock_oh_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]    <= op_d[i];
        tag_q[i]   <= tag_d[i];
        rdy_q[i]   <= rdy_d[i];
        stag_q[i]  <= stag_d[i];
        sdata_q[i] <= sdata_d[i];
      end
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) ex_fire |-> count_q != '0);
  a_cdb_unique: assert property (@(posedge clk) disable iff (!rst_n) !multi_hit);

endmodule

// File: tb/tb_rs_unit.sv
// Directed bench for rs_unit: allocation, wakeup, bypass, full/backpressure, lock, flush, reset.
module tb_rs_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [5:0]  in_tag;
  logic [1:0]  in_src_rdy;
  logic [11:0] in_src_tag;
  logic [63:0] in_src_data;
  logic [0:0]  cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_op;
  logic [5:0]  ex_tag;
  logic [63:0] ex_src;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  rs_unit #(
    .DEPTH  (4),
    .NSRC   (2),
    .N_CDB  (1),
    .DATA_W (32),
    .TAG_W  (6),
    .OP_W   (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .in_src_rdy  (in_src_rdy),
    .in_src_tag  (in_src_tag),
    .in_src_data (in_src_data),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_op       (ex_op),
    .ex_tag      (ex_tag),
    .ex_src      (ex_src),
    .count       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] tag, input logic [1:0] rdy,
                       input logic [11:0] stag, input logic [63:0] sdata);
    in_valid    = 1'b1;
    in_op       = op;
    in_tag      = tag;
    in_src_rdy  = rdy;
    in_src_tag  = stag;
    in_src_data = sdata;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_tag = '0;
    in_src_rdy = '0; in_src_tag = '0; in_src_data = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; ex_ready = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_ex_payload", {46'd0, ex_op, ex_tag} | ex_src, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: both operands ready
    ex_ready = 1'b1;
    issue(6'h01, 6'd3, 2'b11, 12'd0, {32'h20, 32'h10});
    #1 check("t1_same_cycle", 64'(ex_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check("t1_ex_valid", 64'(ex_valid), 64'd1);
    check("t1_ex_tag", 64'(ex_tag), 64'd3);
    check("t1_ex_op", 64'(ex_op), 64'h01);
    check("t1_ex_src", ex_src, {32'h20, 32'h10});
    check("t1_count", 64'(count), 64'd1);
    tick();
    check("t1_drained", 64'(count), 64'd0);
    check("t1_idle", 64'(ex_valid), 64'd0);

    // 2: src0 waits on tag 7
    issue(6'h02, 6'd5, 2'b10, {6'd0, 6'd7}, {32'h55, 32'h0});
    tick();
    in_valid = 1'b0;
    #1 check("t2_wait", 64'(ex_valid), 64'd0);
    tick();
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'hAB;
    #1 check("t2_wake_cycle", 64'(ex_valid), 64'd0);
    tick();
    cdb_valid = 1'b0;
    #1;
    check("t2_ex_valid", 64'(ex_valid), 64'd1);
    check("t2_ex_tag", 64'(ex_tag), 64'd5);
    check("t2_ex_src", ex_src, {32'h55, 32'hAB});
    tick();
    check("t2_drained", 64'(count), 64'd0);

    // 3: alloc bypass
    issue(6'h03, 6'd8, 2'b10, {6'd0, 6'd9}, {32'h66, 32'h0});
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hCD;
    tick();
    in_valid = 1'b0; cdb_valid = 1'b0;
    #1;
    check("t3_ex_valid", 64'(ex_valid), 64'd1);
    check("t3_ex_src", ex_src, {32'h66, 32'hCD});
    tick();
    check("t3_drained", 64'(count), 64'd0);

    // 4: fill, backpressure, reuse of freed slot, age order
    ex_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(6'h04, 6'(10 + k), 2'b11, 12'd0, 64'(k));
      tick();
    end
    issue(6'h04, 6'd14, 2'b11, 12'd0, 64'd4);
    ex_ready = 1'b1;
    #1;
    check("t4_full_count", 64'(count), 64'd4);
    check("t4_full_ready", 64'(in_ready), 64'd0);
    check("t4_oldest", 64'(ex_tag), 64'd10);
    tick();
    ex_ready = 1'b0;
    #1;
    check("t4_count_3", 64'(count), 64'd3);
    check("t4_ready_1", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    ex_ready = 1'b1;
    #1 check("t4_refill", 64'(count), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_order_%0d", k), 64'(ex_tag), 64'(11 + k));
      tick();
    end
    check("t4_drained", 64'(count), 64'd0);

    // 5: lock holds a stalled pick while an older entry wakes
    ex_ready = 1'b0;
    issue(6'h05, 6'd1, 2'b10, {6'd0, 6'd21}, {32'h11, 32'h0});
    tick();
    issue(6'h05, 6'd2, 2'b11, 12'd0, {32'h22, 32'h02});
    tick();
    in_valid = 1'b0;
    #1 check("t5_pick2", 64'(ex_tag), 64'd2);
    cdb_valid = 1'b1; cdb_tag = 6'd21; cdb_data = 32'h77;
    tick();
    cdb_valid = 1'b0;
    #1 check("t5_locked", 64'(ex_tag), 64'd2);
    ex_ready = 1'b1;
    #1 check("t5_locked_acc", 64'(ex_tag), 64'd2);
    tick();
    check("t5_then1", 64'(ex_tag), 64'd1);
    check("t5_src", ex_src, {32'h11, 32'h77});
    tick();
    check("t5_drained", 64'(count), 64'd0);

    // 6: flush, then async reset mid-run
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      issue(6'h06, 6'(30 + k), 2'b11, 12'd0, 64'd0);
      tick();
    end
    flush = 1'b1;
    #1;
    check("t6_pre_count", 64'(count), 64'd3);
    check("t6_flush_exv", 64'(ex_valid), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("t6_count", 64'(count), 64'd0);
    check("t6_exv", 64'(ex_valid), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 2; k++) begin
      issue(6'h07, 6'(40 + k), 2'b11, 12'd0, 64'd9);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("t6_refill", 64'(count), 64'd2);
    check("t6_refill_exv", 64'(ex_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_exv", 64'(ex_valid), 64'd0);
    check("t6_rst_tag", 64'(ex_tag), 64'd0);
    #1 rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
